// File: rtl/dl_fpu_wb.sv
// Writeback/status stage behind the DLFloat16 FPU: in-order result FIFO feeding the
// register-file write port, plus the frm/fflags/fcsr status registers.
module dl_fpu_wb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_int_dest,
  input  logic [4:0]  in_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_int,
  input  logic        csr_we,
  input  logic [1:0]  csr_addr,
  input  logic [7:0]  csr_wdata,
  output logic [7:0]  csr_rdata,
  output logic [2:0]  frm_out,
  output logic [4:0]  fflags_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ADDR_FFLAGS = 2'b01;
  localparam logic [1:0] ADDR_FRM    = 2'b10;
  localparam logic [1:0] ADDR_FCSR   = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        int_dest;
    logic [4:0]  flags;
  } entry_t;

  // Half-precision results land in FP registers NaN-boxed; integer results pass through.
  function automatic logic [31:0] wb_format(input logic [31:0] res, input logic is_int);
    wb_format = is_int ? res : {16'hFFFF, res[15:0]};
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      fflags_q, fflags_d;
  logic [2:0]      frm_q, frm_d;

  logic   full, empty, push, pop;
  entry_t head;
  logic   flags_wr;
  logic [4:0] flags_base;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign wb_valid = !empty;
  assign pop      = wb_valid && wb_ready;

  assign wb_data    = head.data;
  assign wb_rd      = head.rd;
  assign wb_int     = head.int_dest;
  assign frm_out    = frm_q;
  assign fflags_out = fflags_q;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q].data     = wb_format(in_result, in_int_dest);
      mem_d[wr_ptr_q].rd       = in_rd;
      mem_d[wr_ptr_q].int_dest = in_int_dest;
      mem_d[wr_ptr_q].flags    = in_flags;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // A CSR write replaces the sticky state, but the retiring op's flags still OR on top.
  always_comb begin
    flags_wr   = csr_we && (csr_addr == ADDR_FFLAGS || csr_addr == ADDR_FCSR);
    flags_base = flags_wr ? csr_wdata[4:0] : fflags_q;
    fflags_d   = flags_base | (pop ? head.flags : 5'b0);
    frm_d      = frm_q;
    if (csr_we && csr_addr == ADDR_FRM)  frm_d = csr_wdata[2:0];
    if (csr_we && csr_addr == ADDR_FCSR) frm_d = csr_wdata[7:5];
  end

  always_comb begin
    csr_rdata = 8'h00;
    case (csr_addr)
      ADDR_FFLAGS: csr_rdata = {3'b000, fflags_q};
      ADDR_FRM:    csr_rdata = {5'b00000, frm_q};
      ADDR_FCSR:   csr_rdata = {frm_q, fflags_q};
      default:     csr_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      frm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  // Payload storage is not reset; entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dl_fpu_wb.sv
// Directed bench for dl_fpu_wb: FIFO order/backpressure, NaN-boxing, CSR and reset behaviour.
module tb_dl_fpu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_int_dest;
  logic [4:0]  in_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_int;
  logic        csr_we;
  logic [1:0]  csr_addr;
  logic [7:0]  csr_wdata;
  logic [7:0]  csr_rdata;
  logic [2:0]  frm_out;
  logic [4:0]  fflags_out;

  int vectors = 0;
  int miscompares = 0;

  dl_fpu_wb #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_rd(in_rd), .in_int_dest(in_int_dest), .in_flags(in_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_int(wb_int),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .frm_out(frm_out), .fflags_out(fflags_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = '0; in_int_dest = 1'b0;
    in_flags = '0; wb_ready = 1'b0; csr_we = 1'b0; csr_addr = 2'b00; csr_wdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_fflags", 32'(fflags_out), 32'd0);
    chk("rst_frm", 32'(frm_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // One FP op, NaN-boxed, flags visible the cycle after the pop
    in_valid = 1'b1; in_result = 32'h0000_3E00; in_rd = 5'd3; in_flags = 5'b00001;
    wb_ready = 1'b1;
    #1;
    chk("no_bypass", 32'(wb_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("fp_wb_valid", 32'(wb_valid), 32'd1);
    chk("fp_wb_data", wb_data, 32'hFFFF_3E00);
    chk("fp_wb_rd", 32'(wb_rd), 32'd3);
    chk("fp_wb_int", 32'(wb_int), 32'd0);
    chk("fp_fflags_before_pop", 32'(fflags_out), 32'd0);
    tick();
    chk("fp_fflags_after_pop", 32'(fflags_out), 32'b00001);
    chk("fp_drained", 32'(wb_valid), 32'd0);

    // Backpressure: 5 back-to-back pushes into a 4-deep FIFO
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_result = 32'h0000_1000 + 32'(i); in_rd = 5'(8 + i);
      in_flags = 5'b0;
      #1;
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("bp_head_stable_%0d", i), wb_data, 32'hFFFF_1000);
      tick();
    end
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head_rd", 32'(wb_rd), 32'd8);
    wb_ready = 1'b1;
    #1;
    chk("bp_no_comb_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_wb1", wb_data, 32'hFFFF_1001);
    tick();
    in_valid = 1'b0;
    chk("bp_wb2", wb_data, 32'hFFFF_1002);
    chk("bp_wb2_rd", 32'(wb_rd), 32'd10);
    tick();
    chk("bp_wb3", wb_data, 32'hFFFF_1003);
    tick();
    chk("bp_wb4", wb_data, 32'hFFFF_1004);
    chk("bp_wb4_rd", 32'(wb_rd), 32'd12);
    tick();
    chk("bp_drained", 32'(wb_valid), 32'd0);
    chk("bp_fflags_kept", 32'(fflags_out), 32'b00001);

    // Integer destinations pass through unchanged
    in_valid = 1'b1; in_int_dest = 1'b1; in_result = 32'hFFFF_FF85; in_rd = 5'd10;
    in_flags = 5'b10000;
    tick();
    in_result = 32'h1234_5678; in_rd = 5'd11; in_flags = 5'b00000;
    chk("int_wb_data", wb_data, 32'hFFFF_FF85);
    chk("int_wb_int", 32'(wb_int), 32'd1);
    chk("int_wb_rd", 32'(wb_rd), 32'd10);
    tick();
    in_valid = 1'b0; in_int_dest = 1'b0;
    chk("int_wb_data2", wb_data, 32'h1234_5678);
    tick();
    chk("int_fflags", 32'(fflags_out), 32'b10001);

    // CSR write of fflags, then write concurrent with a retire
    csr_we = 1'b1; csr_addr = 2'b01; csr_wdata = 8'h10;
    tick();
    csr_we = 1'b0;
    chk("csr_fflags_rd", 32'(csr_rdata), 32'h10);
    wb_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h0000_0001; in_rd = 5'd1; in_flags = 5'b00100;
    tick();
    in_valid = 1'b0;
    wb_ready = 1'b1; csr_we = 1'b1; csr_addr = 2'b01; csr_wdata = 8'h00;
    tick();
    csr_we = 1'b0;
    chk("csr_and_retire", 32'(fflags_out), 32'b00100);

    // fcsr write and readback views
    csr_we = 1'b1; csr_addr = 2'b11; csr_wdata = 8'b011_00010;
    tick();
    csr_we = 1'b0;
    chk("fcsr_frm", 32'(frm_out), 32'd3);
    chk("fcsr_fflags", 32'(fflags_out), 32'b00010);
    chk("fcsr_rd", 32'(csr_rdata), 32'h62);
    csr_addr = 2'b10;
    #1;
    chk("frm_rd", 32'(csr_rdata), 32'h03);
    csr_addr = 2'b00;
    #1;
    chk("addr0_rd", 32'(csr_rdata), 32'h00);
    csr_we = 1'b1; csr_addr = 2'b00; csr_wdata = 8'hFF;
    tick();
    csr_we = 1'b0;
    chk("addr0_we_frm", 32'(frm_out), 32'd3);
    chk("addr0_we_fflags", 32'(fflags_out), 32'b00010);
    csr_we = 1'b1; csr_addr = 2'b10; csr_wdata = 8'h05;
    tick();
    csr_we = 1'b0;
    chk("frm_reserved_kept", 32'(frm_out), 32'd5);

    // Reset mid-stream discards entries; CSR write in reset cycle ignored
    csr_we = 1'b1; csr_addr = 2'b01; csr_wdata = 8'h01;
    tick();
    csr_we = 1'b0;
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = 32'h0000_2000 + 32'(i); in_rd = 5'(20 + i);
      in_flags = 5'b11111;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_buffered", 32'(wb_valid), 32'd1);
    chk("mid_fflags", 32'(fflags_out), 32'b00001);
    rst = 1'b1; wb_ready = 1'b1; csr_we = 1'b1; csr_addr = 2'b01; csr_wdata = 8'h1F;
    tick();
    rst = 1'b0; csr_we = 1'b0;
    #1;
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_fflags", 32'(fflags_out), 32'd0);
    chk("mid_rst_frm", 32'(frm_out), 32'd0);
    in_valid = 1'b1; in_result = 32'h0000_ABCD; in_rd = 5'd7; in_flags = 5'b00010;
    tick();
    in_valid = 1'b0;
    chk("post_rst_wb_valid", 32'(wb_valid), 32'd1);
    chk("post_rst_wb_data", wb_data, 32'hFFFF_ABCD);
    chk("post_rst_wb_rd", 32'(wb_rd), 32'd7);
    tick();
    chk("post_rst_drained", 32'(wb_valid), 32'd0);
    chk("post_rst_fflags", 32'(fflags_out), 32'b00010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
